// File: rtl/btb_update_scheduler.sv
// btb_update_scheduler
// Buffers resolved branch outcomes from EXEC in a small FIFO and replays them
// to the BTB write port one per free cycle. It also walks every BTB line to
// carry out a full-table invalidate (fence.i / context switch), and pulses
// inv_done_o when the walk completes.
//
// Optional feature macro: BTB_SCHED_MERGE_EN
//   When defined, a push whose current address matches a queued entry updates
//   that entry's next address in place instead of allocating a new slot. The
//   head entry is excluded only when it is leaving the queue in the same cycle.
//   When undefined, every accepted push allocates and no compare logic exists.

module btb_update_scheduler #(
    parameter int NUM_BTBL    = 16,
    parameter int XLEN        = 64,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           upd_valid_i,
    output logic                           upd_ready_o,
    input  logic [XLEN-1:0]                upd_current_addr_i,
    input  logic [XLEN-1:0]                upd_next_addr_i,
    input  logic                           inv_req_i,
    input  logic                           stall_i,
    output logic                           btb_valid_o,
    output logic [XLEN-1:0]                btb_current_addr_o,
    output logic [XLEN-1:0]                btb_next_addr_o,
    output logic                           btb_inv_o,
    output logic [$clog2(NUM_BTBL)-1:0]    btb_inv_index_o,
    output logic                           inv_busy_o,
    output logic                           inv_done_o,
    output logic [$clog2(QUEUE_DEPTH):0]   count_o
);

    localparam int IDX_W = $clog2(NUM_BTBL);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(QUEUE_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BTBL - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] sweep_idx;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [XLEN-1:0] cur_mem [QUEUE_DEPTH];
    logic [XLEN-1:0] nxt_mem [QUEUE_DEPTH];

    logic in_idle;
    logic in_sweep;
    logic full;
    logic drain;
    logic accept;
    logic alloc;
    logic merge_hit;

    assign in_idle  = rst_ni & (state == IDLE);
    assign in_sweep = rst_ni & (state == SWEEP);
    assign full     = (count == DEPTH_CNT);
    assign drain    = in_idle & ~inv_req_i & ~stall_i & (count != '0);

`ifdef BTB_SCHED_MERGE_EN
    logic [PTR_W-1:0] merge_idx;

    // Find the youngest queued entry with the same current address; the head is skipped while it is being popped
    always_comb begin
        merge_hit = 1'b0;
        merge_idx = head;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if ((CNT_W'(i) < count) && !((i == 0) && drain) &&
                (cur_mem[head + PTR_W'(i)] == upd_current_addr_i)) begin
                merge_hit = 1'b1;
                merge_idx = head + PTR_W'(i);
            end
        end
    end
`else
    assign merge_hit = 1'b0;
`endif

    assign upd_ready_o = in_idle & ~inv_req_i & (~full | merge_hit);
    assign accept      = upd_valid_i & upd_ready_o;
    assign alloc       = accept & ~merge_hit;

    // Queue storage: allocate at the tail, or rewrite a matching entry's target when merging
    always_ff @(posedge clk_i) begin
        if (alloc) begin
            cur_mem[tail] <= upd_current_addr_i;
            nxt_mem[tail] <= upd_next_addr_i;
        end
`ifdef BTB_SCHED_MERGE_EN
        else if (accept) begin
            nxt_mem[merge_idx] <= upd_next_addr_i;
        end
`endif
    end

    // Control FSM with queue pointers, occupancy and sweep index
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= IDLE;
            sweep_idx <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (inv_req_i) begin
                        state     <= SWEEP;
                        sweep_idx <= '0;
                        head      <= '0;
                        tail      <= '0;
                        count     <= '0;
                    end else begin
                        if (alloc) begin
                            tail <= tail + PTR_W'(1);
                        end
                        if (drain) begin
                            head <= head + PTR_W'(1);
                        end
                        if (alloc && !drain) begin
                            count <= count + CNT_W'(1);
                        end else if (!alloc && drain) begin
                            count <= count - CNT_W'(1);
                        end
                    end
                end
                SWEEP: begin
                    if (!stall_i) begin
                        if (sweep_idx == LAST_IDX) begin
                            state     <= DONE;
                            sweep_idx <= '0;
                        end else begin
                            sweep_idx <= sweep_idx + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign btb_valid_o        = drain;
    assign btb_current_addr_o = drain ? cur_mem[head] : '0;
    assign btb_next_addr_o    = drain ? nxt_mem[head] : '0;
    assign btb_inv_o          = in_sweep & ~stall_i;
    assign btb_inv_index_o    = in_sweep ? sweep_idx : '0;
    assign inv_busy_o         = in_sweep | (in_idle & inv_req_i);
    assign inv_done_o         = rst_ni & (state == DONE);
    assign count_o            = rst_ni ? count : '0;

endmodule

// File: tb/tb_btb_update_scheduler.sv
// tb_btb_update_scheduler
// Drives directed scenarios followed by randomized traffic into
// btb_update_scheduler and compares every output, every cycle, against a
// queue-based behavioural model. Build with +define+BTB_SCHED_MERGE_EN to
// exercise the merge feature (the model follows the same macro).

module tb_btb_update_scheduler;

    localparam int NUM_BTBL    = 16;
    localparam int XLEN        = 64;
    localparam int QUEUE_DEPTH = 4;

    localparam int M_IDLE  = 0;
    localparam int M_SWEEP = 1;
    localparam int M_DONE  = 2;

    typedef struct {
        logic [63:0] cur;
        logic [63:0] nxt;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        upd_valid;
    logic        upd_ready;
    logic [63:0] upd_cur;
    logic [63:0] upd_nxt;
    logic        inv_req;
    logic        stall;
    logic        btb_valid;
    logic [63:0] btb_cur;
    logic [63:0] btb_nxt;
    logic        btb_inv;
    logic [3:0]  btb_inv_index;
    logic        inv_busy;
    logic        inv_done;
    logic [2:0]  count;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    ent_t q[$];
    int   mode = M_IDLE;
    int   sw   = 0;

    // Expectations for the current cycle, reused when the model advances
    logic e_valid;
    logic e_ready;
    int   e_hit;

    always #5 clk = ~clk;

    btb_update_scheduler #(
        .NUM_BTBL   (NUM_BTBL),
        .XLEN       (XLEN),
        .QUEUE_DEPTH(QUEUE_DEPTH)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .upd_valid_i       (upd_valid),
        .upd_ready_o       (upd_ready),
        .upd_current_addr_i(upd_cur),
        .upd_next_addr_i   (upd_nxt),
        .inv_req_i         (inv_req),
        .stall_i           (stall),
        .btb_valid_o       (btb_valid),
        .btb_current_addr_o(btb_cur),
        .btb_next_addr_o   (btb_nxt),
        .btb_inv_o         (btb_inv),
        .btb_inv_index_o   (btb_inv_index),
        .inv_busy_o        (inv_busy),
        .inv_done_o        (inv_done),
        .count_o           (count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Youngest queued entry matching the offered address, or -1
    function automatic int modelHit(input logic popping);
        int r = -1;
`ifdef BTB_SCHED_MERGE_EN
        for (int k = 0; k < q.size(); k++) begin
            if (!(k == 0 && popping) && q[k].cur == upd_cur) r = k;
        end
`endif
        return r;
    endfunction

    task automatic checkOutput();
        logic        idle_now;
        logic        sweep_now;
        logic [63:0] e_cur;
        logic [63:0] e_nxt;
        idle_now  = rst_n && (mode == M_IDLE);
        sweep_now = rst_n && (mode == M_SWEEP);
        e_valid   = idle_now && (q.size() != 0) && !stall && !inv_req;
        e_hit     = modelHit(e_valid);
        e_ready   = idle_now && !inv_req && ((q.size() < QUEUE_DEPTH) || (e_hit >= 0));
        e_cur     = e_valid ? q[0].cur : 64'h0;
        e_nxt     = e_valid ? q[0].nxt : 64'h0;
        check("upd_ready", upd_ready, e_ready);
        check("btb_valid", btb_valid, e_valid);
        if (e_valid) begin
            check("btb_cur", btb_cur, e_cur);
            check("btb_nxt", btb_nxt, e_nxt);
        end
        check("btb_inv", btb_inv, sweep_now && !stall);
        check("btb_inv_index", btb_inv_index, sweep_now ? sw : 0);
        check("inv_busy", inv_busy, sweep_now || (idle_now && inv_req));
        check("inv_done", inv_done, rst_n && (mode == M_DONE));
        check("count", count, rst_n ? q.size() : 0);
        check("valid_inv_excl", btb_valid & btb_inv, 1'b0);
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [63:0] c,
                                 input logic [63:0] n, input logic iv, input logic st);
        @(negedge clk);
        rst_n     = r;
        upd_valid = v;
        upd_cur   = c;
        upd_nxt   = n;
        inv_req   = iv;
        stall     = st;
        #1;
        checkOutput();
    endtask

    // Advance the model across the clock edge using this cycle's inputs
    task automatic tick();
        ent_t e;
        logic pushing;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            mode = M_IDLE;
            sw   = 0;
        end else begin
            case (mode)
                M_IDLE: begin
                    if (inv_req) begin
                        q.delete();
                        mode = M_SWEEP;
                        sw   = 0;
                    end else begin
                        pushing = upd_valid && e_ready;
                        if (pushing && e_hit >= 0) q[e_hit].nxt = upd_nxt;
                        if (e_valid) void'(q.pop_front());
                        if (pushing && e_hit < 0) begin
                            e.cur = upd_cur;
                            e.nxt = upd_nxt;
                            q.push_back(e);
                        end
                    end
                end
                M_SWEEP: begin
                    if (!stall) begin
                        if (sw == NUM_BTBL - 1) begin
                            mode = M_DONE;
                            sw   = 0;
                        end else begin
                            sw++;
                        end
                    end
                end
                default: mode = M_IDLE;
            endcase
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [63:0] c,
                        input logic [63:0] n, input logic iv, input logic st);
        applyStimulus(r, v, c, n, iv, st);
        tick();
    endtask

    logic [63:0] addrs [5];

    initial begin
        rst_n = 1'b0; upd_valid = 1'b0; upd_cur = '0; upd_nxt = '0;
        inv_req = 1'b0; stall = 1'b0;

        // Reset: outputs held low even with traffic offered
        applyStimulus(1'b0, 1'b1, 64'h1000, 64'h2000, 1'b0, 1'b0);
        check("rst_ready", upd_ready, 1'b0);
        check("rst_count", count, 3'd0);
        tick();
        step(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);

        // Single push, presented the following cycle, then queue empties
        applyStimulus(1'b1, 1'b1, 64'h1000, 64'h2000, 1'b0, 1'b0);
        check("push1_ready", upd_ready, 1'b1);
        check("push1_nobypass", btb_valid, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        check("push1_valid", btb_valid, 1'b1);
        check("push1_cur", btb_cur, 64'h1000);
        check("push1_nxt", btb_nxt, 64'h2000);
        tick();
        applyStimulus(1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        check("push1_count0", count, 3'd0);
        tick();

        // Fill while stalled: 4 accepted, 5th refused; then drain in order
        for (int k = 0; k < 5; k++) addrs[k] = 64'h100 * (k + 1);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b1, addrs[k], addrs[k] + 64'h8, 1'b0, 1'b1);
            if (k == 4) begin
                check("full_ready", upd_ready, 1'b0);
                check("full_count", count, 3'd4);
            end
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
            check("drain_valid", btb_valid, 1'b1);
            check("drain_order", btb_cur, addrs[k]);
            tick();
        end

        // Three entries pending, then invalidate with a 3-cycle stall at index 7
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, addrs[k], 64'h55, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
        check("inv_req_busy", inv_busy, 1'b1);
        check("inv_req_ready", upd_ready, 1'b0);
        tick();
        for (int i = 0; i < NUM_BTBL; i++) begin
            if (i == 7) begin
                for (int s = 0; s < 3; s++) begin
                    applyStimulus(1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1);
                    check("sweep_stall_inv", btb_inv, 1'b0);
                    check("sweep_stall_idx", btb_inv_index, 4'd7);
                    tick();
                end
            end
            applyStimulus(1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
            if (i == 0) check("sweep_flushed", count, 3'd0);
            check("sweep_inv", btb_inv, 1'b1);
            check("sweep_idx", btb_inv_index, i[3:0]);
            check("sweep_busy", inv_busy, 1'b1);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        check("sweep_done", inv_done, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        check("sweep_done_once", inv_done, 1'b0);
        tick();

        // Reset while the sweep sits at index 5: no completion pulse afterwards
        step(1'b1, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 64'h40, 64'h44, 1'b0, 1'b0);
        check("midrst_inv", btb_inv, 1'b0);
        check("midrst_busy", inv_busy, 1'b0);
        check("midrst_idx", btb_inv_index, 4'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
            check("midrst_nodone", inv_done, 1'b0);
            check("midrst_idle_busy", inv_busy, 1'b0);
            tick();
        end

`ifdef BTB_SCHED_MERGE_EN
        // Two pushes to the same address while stalled merge into one entry
        step(1'b1, 1'b1, 64'h1000, 64'h2000, 1'b0, 1'b1);
        step(1'b1, 1'b1, 64'h1000, 64'h3000, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        check("merge_count", count, 3'd1);
        check("merge_nxt", btb_nxt, 64'h3000);
        tick();
        applyStimulus(1'b1, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
        check("merge_single", btb_valid, 1'b0);
        tick();
`endif

        // Randomized traffic with a small address pool so merges and full queues occur
        for (int c = 0; c < 4000; c++) begin
            logic r, v, iv, st;
            logic [63:0] a, n;
            r  = ($urandom_range(0, 199) != 0);
            v  = ($urandom_range(0, 9) < 6);
            iv = ($urandom_range(0, 99) < 3);
            st = ($urandom_range(0, 9) < 3);
            a  = 64'h1000 + 64'(4 * $urandom_range(0, 5));
            n  = {$urandom(), $urandom()};
            step(r, v, a, n, iv, st);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
